// File: rtl/tep_mem_pkg.sv
// Shared types and constants for the TEP main-memory arbiter.
// Bank lanes are big-endian: lane 0 is the even bank and carries the high byte.
package tep_mem_pkg;

    localparam int unsigned ADRW_DEF = 11;
    localparam int unsigned ADRS_W   = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned OWN_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_RD      = 2'd0,
        KIND_WR_WORD = 2'd1,
        KIND_WR_BYTE = 2'd2
    } kind_t;

    localparam logic [OWN_W-1:0] OWN_IDLE = 2'b00;
    localparam logic [OWN_W-1:0] OWN_CPU  = 2'b01;
    localparam logic [OWN_W-1:0] OWN_DMA  = 2'b10;

    localparam logic LANE_EVEN = 1'b0;
    localparam logic LANE_ODD  = 1'b1;

    // Granted request as seen by the memory side.
    typedef struct packed {
        kind_t               kind;
        logic [ADRS_W-1:0]   adrs;
        logic [DATA_W-1:0]   data;
    } req_t;

    function automatic logic byte_lane(input logic adr0);
        return adr0 ? LANE_ODD : LANE_EVEN;
    endfunction

endpackage

// File: rtl/tep_lane_wr.sv
// Write-enable and data-lane steering for the even/odd byte banks.
module tep_lane_wr
    import tep_mem_pkg::*;
(
    input  kind_t             kind,
    input  logic              adr0,
    input  logic [DATA_W-1:0] datao,
    output logic              we_e_c,
    output logic              we_o_c,
    output logic [BYTE_W-1:0] wd_e_c,
    output logic [BYTE_W-1:0] wd_o_c
);

    always_comb begin
        we_e_c = 1'b0;
        we_o_c = 1'b0;
        wd_e_c = '0;
        wd_o_c = '0;
        case (kind)
            KIND_WR_WORD: begin
                we_e_c = 1'b1;
                we_o_c = 1'b1;
                wd_e_c = datao[DATA_W-1:BYTE_W];
                wd_o_c = datao[BYTE_W-1:0];
            end
            // Byte writes always take the low data byte, whichever bank they land in.
            KIND_WR_BYTE: begin
                if (byte_lane(adr0) == LANE_EVEN) begin
                    we_e_c = 1'b1;
                    wd_e_c = datao[BYTE_W-1:0];
                end else begin
                    we_o_c = 1'b1;
                    wd_o_c = datao[BYTE_W-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tep_mem_arb.sv
// TEP main-memory arbiter: CPU vs read-only DMA, three-state access sequencer
// driving two synchronous byte banks and returning big-endian words.
module tep_mem_arb
    import tep_mem_pkg::*;
#(
    parameter int unsigned ADRW  = ADRW_DEF,
    parameter bit          RR_EN = 1'b1
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_write_byte,
    input  logic [ADRS_W-1:0] cpu_adrs,
    input  logic [DATA_W-1:0] cpu_datao,
    output logic [DATA_W-1:0] cpu_datai,
    output logic              cpu_ack,
    input  logic              dma_read,
    input  logic [ADRS_W-1:0] dma_adrs,
    output logic [DATA_W-1:0] dma_datai,
    output logic              dma_ack,
    output logic [ADRW-1:0]   mem_adr,
    output logic              mem_we_e,
    output logic              mem_we_o,
    output logic [BYTE_W-1:0] mem_wd_e,
    output logic [BYTE_W-1:0] mem_wd_o,
    input  logic [BYTE_W-1:0] mem_rd_e,
    input  logic [BYTE_W-1:0] mem_rd_o,
    output logic [OWN_W-1:0]  owner
);

    state_t             state, state_nxt;
    logic               last_dma, last_dma_nxt;
    logic               cpu_req_c, gnt_cpu_c, gnt_dma_c;
    kind_t              cpu_kind_c;
    req_t               gnt_req_c;
    logic               lane_we_e_c, lane_we_o_c;
    logic [BYTE_W-1:0]  lane_wd_e_c, lane_wd_o_c;
    logic               unused_adrs_c;

    logic [DATA_W-1:0]  cpu_datai_nxt, dma_datai_nxt;
    logic               cpu_ack_nxt, dma_ack_nxt;
    logic [ADRW-1:0]    mem_adr_nxt;
    logic               mem_we_e_nxt, mem_we_o_nxt;
    logic [BYTE_W-1:0]  mem_wd_e_nxt, mem_wd_o_nxt;
    logic [OWN_W-1:0]   owner_nxt;

    // Arbitration and selection of the candidate request for the next grant.
    always_comb begin
        cpu_req_c  = cpu_read | cpu_write;
        cpu_kind_c = KIND_RD;
        if (cpu_write) begin
            cpu_kind_c = cpu_write_byte ? KIND_WR_BYTE : KIND_WR_WORD;
        end
        gnt_cpu_c = 1'b0;
        gnt_dma_c = 1'b0;
        if (cpu_req_c && dma_read) begin
            if (RR_EN && !last_dma) begin
                gnt_dma_c = 1'b1;
            end else begin
                gnt_cpu_c = 1'b1;
            end
        end else begin
            gnt_cpu_c = cpu_req_c;
            gnt_dma_c = dma_read;
        end
        gnt_req_c.kind = cpu_kind_c;
        gnt_req_c.adrs = cpu_adrs;
        gnt_req_c.data = cpu_datao;
        if (gnt_dma_c) begin
            gnt_req_c.kind = KIND_RD;
            gnt_req_c.adrs = dma_adrs;
            gnt_req_c.data = '0;
        end
    end

    // Address bits above the bank range wrap and are deliberately dropped.
    assign unused_adrs_c = ^gnt_req_c.adrs;

    tep_lane_wr u_lane_wr (
        .kind   (gnt_req_c.kind),
        .adr0   (gnt_req_c.adrs[0]),
        .datao  (gnt_req_c.data),
        .we_e_c (lane_we_e_c),
        .we_o_c (lane_we_o_c),
        .wd_e_c (lane_wd_e_c),
        .wd_o_c (lane_wd_o_c)
    );

    // Access sequencer: next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        last_dma_nxt  = last_dma;
        cpu_datai_nxt = cpu_datai;
        dma_datai_nxt = dma_datai;
        cpu_ack_nxt   = 1'b0;
        dma_ack_nxt   = 1'b0;
        mem_adr_nxt   = mem_adr;
        mem_we_e_nxt  = 1'b0;
        mem_we_o_nxt  = 1'b0;
        mem_wd_e_nxt  = mem_wd_e;
        mem_wd_o_nxt  = mem_wd_o;
        owner_nxt     = owner;
        case (state)
            ST_IDLE: begin
                if (gnt_cpu_c || gnt_dma_c) begin
                    state_nxt    = ST_ISSUE;
                    last_dma_nxt = gnt_dma_c;
                    mem_adr_nxt  = gnt_req_c.adrs[ADRW:1];
                    mem_we_e_nxt = lane_we_e_c;
                    mem_we_o_nxt = lane_we_o_c;
                    mem_wd_e_nxt = lane_wd_e_c;
                    mem_wd_o_nxt = lane_wd_o_c;
                    owner_nxt    = gnt_dma_c ? OWN_DMA : OWN_CPU;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_DONE;
            end
            // Bank read data is valid here, one cycle after the address was presented.
            ST_DONE: begin
                state_nxt = ST_IDLE;
                owner_nxt = OWN_IDLE;
                if (owner == OWN_DMA) begin
                    dma_ack_nxt   = 1'b1;
                    dma_datai_nxt = {mem_rd_e, mem_rd_o};
                end else begin
                    cpu_ack_nxt   = 1'b1;
                    cpu_datai_nxt = {mem_rd_e, mem_rd_o};
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state     <= ST_IDLE;
            last_dma  <= 1'b1;
            cpu_datai <= '0;
            dma_datai <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            mem_adr   <= '0;
            mem_we_e  <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_wd_e  <= '0;
            mem_wd_o  <= '0;
            owner     <= OWN_IDLE;
        end else begin
            state     <= state_nxt;
            last_dma  <= last_dma_nxt;
            cpu_datai <= cpu_datai_nxt;
            dma_datai <= dma_datai_nxt;
            cpu_ack   <= cpu_ack_nxt;
            dma_ack   <= dma_ack_nxt;
            mem_adr   <= mem_adr_nxt;
            mem_we_e  <= mem_we_e_nxt;
            mem_we_o  <= mem_we_o_nxt;
            mem_wd_e  <= mem_wd_e_nxt;
            mem_wd_o  <= mem_wd_o_nxt;
            owner     <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_tep_mem_arb.sv
// Bench for tep_mem_arb: round-robin and fixed-priority instances share stimulus,
// each with its own pair of synchronous byte banks; a byte-addressed shadow memory predicts reads.
module tb_tep_mem_arb;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        cpu_read, cpu_write, cpu_write_byte, dma_read;
    logic [15:0] cpu_adrs, cpu_datao, dma_adrs;

    logic [15:0] cpu_datai0, dma_datai0, cpu_datai1, dma_datai1;
    logic        cpu_ack0, dma_ack0, cpu_ack1, dma_ack1;
    logic [10:0] mem_adr0, mem_adr1;
    logic        mem_we_e0, mem_we_o0, mem_we_e1, mem_we_o1;
    logic [7:0]  mem_wd_e0, mem_wd_o0, mem_wd_e1, mem_wd_o1;
    logic [7:0]  mem_rd_e0, mem_rd_o0, mem_rd_e1, mem_rd_o1;
    logic [1:0]  owner0, owner1;

    logic [7:0]  ram_e0 [2048];
    logic [7:0]  ram_o0 [2048];
    logic [7:0]  ram_e1 [2048];
    logic [7:0]  ram_o1 [2048];
    logic        pl_clr, pl_we;
    logic [10:0] pl_adr;
    logic [7:0]  pl_e, pl_o;

    logic [7:0]  shadow [4096];
    int          checks = 0;
    int          errors = 0;

    always #5 m_clock = ~m_clock;

    tep_mem_arb #(.ADRW(11), .RR_EN(1'b1)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_write_byte(cpu_write_byte),
        .cpu_adrs(cpu_adrs), .cpu_datao(cpu_datao), .cpu_datai(cpu_datai0), .cpu_ack(cpu_ack0),
        .dma_read(dma_read), .dma_adrs(dma_adrs), .dma_datai(dma_datai0), .dma_ack(dma_ack0),
        .mem_adr(mem_adr0), .mem_we_e(mem_we_e0), .mem_we_o(mem_we_o0),
        .mem_wd_e(mem_wd_e0), .mem_wd_o(mem_wd_o0),
        .mem_rd_e(mem_rd_e0), .mem_rd_o(mem_rd_o0), .owner(owner0)
    );

    tep_mem_arb #(.ADRW(11), .RR_EN(1'b0)) dut_fp (
        .m_clock(m_clock), .p_reset(p_reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_write_byte(cpu_write_byte),
        .cpu_adrs(cpu_adrs), .cpu_datao(cpu_datao), .cpu_datai(cpu_datai1), .cpu_ack(cpu_ack1),
        .dma_read(dma_read), .dma_adrs(dma_adrs), .dma_datai(dma_datai1), .dma_ack(dma_ack1),
        .mem_adr(mem_adr1), .mem_we_e(mem_we_e1), .mem_we_o(mem_we_o1),
        .mem_wd_e(mem_wd_e1), .mem_wd_o(mem_wd_o1),
        .mem_rd_e(mem_rd_e1), .mem_rd_o(mem_rd_o1), .owner(owner1)
    );

    // Synchronous banks with a bench-side preload port.
    always @(posedge m_clock) begin
        if (pl_clr) begin
            for (int i = 0; i < 2048; i++) begin
                ram_e0[i] <= 8'h00; ram_o0[i] <= 8'h00;
                ram_e1[i] <= 8'h00; ram_o1[i] <= 8'h00;
            end
        end else if (pl_we) begin
            ram_e0[pl_adr] <= pl_e; ram_o0[pl_adr] <= pl_o;
            ram_e1[pl_adr] <= pl_e; ram_o1[pl_adr] <= pl_o;
        end else begin
            if (mem_we_e0) ram_e0[mem_adr0] <= mem_wd_e0;
            if (mem_we_o0) ram_o0[mem_adr0] <= mem_wd_o0;
            if (mem_we_e1) ram_e1[mem_adr1] <= mem_wd_e1;
            if (mem_we_o1) ram_o1[mem_adr1] <= mem_wd_o1;
        end
        mem_rd_e0 <= ram_e0[mem_adr0];
        mem_rd_o0 <= ram_o0[mem_adr0];
        mem_rd_e1 <= ram_e1[mem_adr1];
        mem_rd_o1 <= ram_o1[mem_adr1];
    end

    typedef struct {
        logic        dma;
        logic        rd_too;
        logic        wr;
        logic        byt;
        logic [15:0] adrs;
        logic [15:0] data;
        logic [10:0] exp_adr;
        logic        exp_we_e;
        logic        exp_we_o;
        logic [7:0]  exp_wd_e;
        logic [7:0]  exp_wd_o;
        logic [15:0] exp_rd;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    function automatic vec_t mk(input logic dma, input logic rd_too, input logic wr,
                                input logic byt, input logic [15:0] adrs, input logic [15:0] data,
                                input logic [10:0] ea, input logic we_e, input logic we_o,
                                input logic [7:0] wd_e, input logic [7:0] wd_o,
                                input logic [15:0] erd);
        vec_t v;
        v.dma = dma; v.rd_too = rd_too; v.wr = wr; v.byt = byt;
        v.adrs = adrs; v.data = data; v.exp_adr = ea;
        v.exp_we_e = we_e; v.exp_we_o = we_o; v.exp_wd_e = wd_e; v.exp_wd_o = wd_o;
        v.exp_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    function automatic logic [15:0] sh_word(input logic [15:0] a);
        logic [11:0] b;
        b = {a[11:1], 1'b0};
        return {shadow[b], shadow[b | 12'd1]};
    endfunction

    task automatic sh_write(input logic [15:0] a, input logic [15:0] d, input logic byt);
        if (byt) begin
            shadow[a[11:0]] = d[7:0];
        end else begin
            shadow[{a[11:1], 1'b0}] = d[15:8];
            shadow[{a[11:1], 1'b1}] = d[7:0];
        end
    endtask

    task automatic drop_all();
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_write_byte = 1'b0; dma_read = 1'b0;
    endtask

    // One access from a single requester on the round-robin instance.
    task automatic do_access(input logic dma, input logic rd_too, input logic wr, input logic byt,
                             input logic [15:0] a, input logic [15:0] d,
                             output int lat, output logic [15:0] rdat, output logic [10:0] i_adr,
                             output logic i_we_e, output logic i_we_o,
                             output logic [7:0] i_wd_e, output logic [7:0] i_wd_o);
        bit done;
        done = 0; lat = 0; rdat = '0; i_adr = '0;
        i_we_e = 0; i_we_o = 0; i_wd_e = '0; i_wd_o = '0;
        if (dma) begin
            dma_read = 1'b1; dma_adrs = a;
        end else begin
            cpu_read = rd_too | ~wr; cpu_write = wr; cpu_write_byte = byt;
            cpu_adrs = a; cpu_datao = d;
        end
        while (!done && lat < 10) begin
            tick();
            lat++;
            if (lat == 1) begin
                i_adr = mem_adr0; i_we_e = mem_we_e0; i_we_o = mem_we_o0;
                i_wd_e = mem_wd_e0; i_wd_o = mem_wd_o0;
            end
            if (dma ? dma_ack0 : cpu_ack0) begin
                done = 1;
                rdat = dma ? dma_datai0 : cpu_datai0;
            end
        end
        drop_all();
        if (!dma && wr) sh_write(a, d, byt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, n, since, cyc, fp_cpu, fp_dma;
        logic [15:0] rdat, exp_w;
        logic [10:0] i_adr;
        logic        i_we_e, i_we_o, got, last_dma, exp_dma;
        logic [7:0]  i_wd_e, i_wd_o;

        vt[0]  = mk(0, 0, 0, 0, 16'h000A, 16'h0000, 11'd5, 0, 0, 8'h00, 8'h00, 16'h1234);
        vt[1]  = mk(0, 0, 1, 0, 16'h0010, 16'hBEEF, 11'd8, 1, 1, 8'hBE, 8'hEF, 16'h0000);
        vt[2]  = mk(0, 0, 1, 1, 16'h0011, 16'h0077, 11'd8, 0, 1, 8'h00, 8'h77, 16'h0000);
        vt[3]  = mk(0, 0, 0, 0, 16'h0010, 16'h0000, 11'd8, 0, 0, 8'h00, 8'h00, 16'hBE77);
        vt[4]  = mk(0, 0, 0, 0, 16'h1002, 16'h0000, 11'd1, 0, 0, 8'h00, 8'h00, 16'hABCD);
        vt[5]  = mk(1, 0, 0, 0, 16'h0011, 16'h0000, 11'd8, 0, 0, 8'h00, 8'h00, 16'hBE77);
        vt[6]  = mk(0, 0, 1, 1, 16'h0004, 16'h1255, 11'd2, 1, 0, 8'h55, 8'h00, 16'h0000);
        vt[7]  = mk(1, 0, 0, 0, 16'h0004, 16'h0000, 11'd2, 0, 0, 8'h00, 8'h00, 16'h5500);
        vt[8]  = mk(0, 1, 1, 0, 16'hF00C, 16'hA5C3, 11'd6, 1, 1, 8'hA5, 8'hC3, 16'h0000);
        vt[9]  = mk(0, 0, 0, 0, 16'h000C, 16'h0000, 11'd6, 0, 0, 8'h00, 8'h00, 16'hA5C3);
        vt[10] = mk(0, 0, 0, 1, 16'h000A, 16'h0000, 11'd5, 0, 0, 8'h00, 8'h00, 16'h1234);

        drop_all();
        cpu_adrs = '0; cpu_datao = '0; dma_adrs = '0;
        p_reset = 1'b1; pl_clr = 1'b1; pl_we = 1'b0; pl_adr = '0; pl_e = '0; pl_o = '0;
        for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
        tick();
        pl_clr = 1'b0;
        pl_we = 1'b1; pl_adr = 11'd5; pl_e = 8'h12; pl_o = 8'h34;
        shadow[10] = 8'h12; shadow[11] = 8'h34;
        tick();
        pl_adr = 11'd1; pl_e = 8'hAB; pl_o = 8'hCD;
        shadow[2] = 8'hAB; shadow[3] = 8'hCD;
        tick();
        pl_we = 1'b0;
        tick();

        chk("rst_cpu_ack", 32'(cpu_ack0), 32'd0);
        chk("rst_dma_ack", 32'(dma_ack0), 32'd0);
        chk("rst_owner", 32'(owner0), 32'd0);
        chk("rst_we", 32'({mem_we_e0, mem_we_o0}), 32'd0);
        chk("rst_adr", 32'(mem_adr0), 32'd0);
        chk("rst_wd", 32'({mem_wd_e0, mem_wd_o0}), 32'd0);
        chk("rst_cpu_datai", 32'(cpu_datai0), 32'd0);
        chk("rst_dma_datai", 32'(dma_datai0), 32'd0);
        p_reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            do_access(vt[i].dma, vt[i].rd_too, vt[i].wr, vt[i].byt, vt[i].adrs, vt[i].data,
                      lat, rdat, i_adr, i_we_e, i_we_o, i_wd_e, i_wd_o);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_adr", i), 32'(i_adr), 32'(vt[i].exp_adr));
            chk($sformatf("vec%0d_we", i), 32'({i_we_e, i_we_o}), 32'({vt[i].exp_we_e, vt[i].exp_we_o}));
            if (vt[i].exp_we_e) chk($sformatf("vec%0d_wd_e", i), 32'(i_wd_e), 32'(vt[i].exp_wd_e));
            if (vt[i].exp_we_o) chk($sformatf("vec%0d_wd_o", i), 32'(i_wd_o), 32'(vt[i].exp_wd_o));
            if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), 32'(rdat), 32'(vt[i].exp_rd));
            tick();
            chk($sformatf("vec%0d_ack_pulse", i), 32'({cpu_ack0, dma_ack0}), 32'd0);
        end

        // Held contention: round-robin alternates, fixed priority starves the DMA.
        p_reset = 1'b1; tick(); p_reset = 1'b0;
        cpu_read = 1'b1; cpu_adrs = 16'h000A; dma_read = 1'b1; dma_adrs = 16'h0010;
        last_dma = 1'b1; n = 0; since = 0; cyc = 0; fp_cpu = 0; fp_dma = 0;
        while (n < 6 && cyc < 60) begin
            tick();
            cyc++; since++;
            if (cpu_ack1) fp_cpu++;
            if (dma_ack1) fp_dma++;
            if (cpu_ack0 || dma_ack0) begin
                exp_dma = !last_dma;
                chk($sformatf("rr_grant%0d", n), 32'({cpu_ack0, dma_ack0}), exp_dma ? 32'd1 : 32'd2);
                chk($sformatf("rr_period%0d", n), 32'(since), 32'd3);
                chk($sformatf("rr_data%0d", n), 32'(exp_dma ? dma_datai0 : cpu_datai0),
                    32'(sh_word(exp_dma ? 16'h0010 : 16'h000A)));
                last_dma = exp_dma; since = 0; n++;
            end
        end
        chk("rr_count", 32'(n), 32'd6);
        cpu_read = 1'b0;
        chk("fp_cpu_grants", 32'(fp_cpu), 32'd6);
        chk("fp_dma_starved", 32'(fp_dma), 32'd0);
        lat = 0; got = 0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            if (dma_ack1) got = 1;
        end
        chk("fp_dma_latency", 32'(lat), 32'd3);
        chk("fp_dma_data", 32'(dma_datai1), 32'(sh_word(16'h0010)));
        dma_read = 1'b0;
        tick(); tick();

        // Randomised traffic against the shadow memory and a round-robin turn model.
        p_reset = 1'b1; tick(); p_reset = 1'b0;
        last_dma = 1'b1;
        for (int it = 0; it < 300; it++) begin
            logic        cr, dr, cw, cb, win_dma;
            logic [15:0] ca, cd, da;
            cr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!cr && !dr) cr = 1'b1;
            cw = ($urandom_range(0, 2) == 0);
            cb = 1'($urandom_range(0, 1));
            ca = 16'($urandom); cd = 16'($urandom); da = 16'($urandom);
            win_dma = dr && (!cr || !last_dma);
            exp_w = sh_word(win_dma ? da : ca);
            cpu_read = cr & (~cw | 1'($urandom_range(0, 1)));
            cpu_write = cr & cw;
            cpu_write_byte = cb;
            cpu_adrs = ca; cpu_datao = cd;
            dma_read = dr; dma_adrs = da;
            lat = 0; got = 0;
            while (!got && lat < 10) begin
                tick();
                lat++;
                if (cpu_ack0 || dma_ack0) got = 1;
            end
            chk($sformatf("rnd%0d_latency", it), 32'(lat), 32'd3);
            chk($sformatf("rnd%0d_winner", it), 32'({cpu_ack0, dma_ack0}), win_dma ? 32'd1 : 32'd2);
            if (win_dma || !cw)
                chk($sformatf("rnd%0d_rdata", it), 32'(win_dma ? dma_datai0 : cpu_datai0), 32'(exp_w));
            drop_all();
            if (!win_dma && cw) sh_write(ca, cd, cb);
            last_dma = win_dma;
            tick();
            chk($sformatf("rnd%0d_ack_pulse", it), 32'({cpu_ack0, dma_ack0}), 32'd0);
        end

        // Reset in the middle of a CPU write: no ack, back to idle, next access normal.
        cpu_write = 1'b1; cpu_adrs = 16'h0020; cpu_datao = 16'hCAFE;
        tick();
        chk("rstmid_issue_owner", 32'(owner0), 32'd1);
        chk("rstmid_issue_we", 32'({mem_we_e0, mem_we_o0}), 32'd3);
        p_reset = 1'b1; cpu_write = 1'b0;
        tick();
        p_reset = 1'b0;
        chk("rstmid_owner", 32'(owner0), 32'd0);
        chk("rstmid_we", 32'({mem_we_e0, mem_we_o0}), 32'd0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ack0 || dma_ack0) n++;
            tick();
        end
        chk("rstmid_no_ack", 32'(n), 32'd0);
        exp_w = sh_word(16'h000A);
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 16'h000A, 16'h0000,
                  lat, rdat, i_adr, i_we_e, i_we_o, i_wd_e, i_wd_o);
        chk("rstmid_read_latency", 32'(lat), 32'd3);
        chk("rstmid_read_data", 32'(rdat), 32'(exp_w));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
